// File: rtl/sp_dram_arbiter.sv
// sp_dram_arbiter: shares the single sp_dram user port among PORTS requesters.
// Round-robin grant, one outstanding DRAM operation at a time. The winning
// request is latched so the requester may move on right after its ack, and
// read data is returned through a shared register with a per-port valid pulse.
module sp_dram_arbiter #(
  parameter int PORTS      = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_valid,
  input  logic [PORTS-1:0]            req_write,
  input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0] req_din,
  input  logic [PORTS*MASK_WIDTH-1:0] req_mask,
  output logic [PORTS-1:0]            req_ack,
  output logic [PORTS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_din,
  output logic [MASK_WIDTH-1:0]       mem_mask,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_WIDTH-1:0]       mem_dout,
  input  logic                        mem_ready,
  output logic                        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RETURN  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [SEL_WIDTH-1:0]  r_last_grant;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [MASK_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [SEL_WIDTH-1:0]  w_grant_idx;
  logic                  w_grant_found;
  logic                  w_start;

  logic [ADDR_WIDTH-1:0] w_addr_arr [PORTS];
  logic [DATA_WIDTH-1:0] w_din_arr  [PORTS];
  logic [MASK_WIDTH-1:0] w_mask_arr [PORTS];

  // Unpack the flat request buses into per-port views
  for (genvar g = 0; g < PORTS; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_din_arr[g]  = req_din[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_mask_arr[g] = req_mask[g*MASK_WIDTH +: MASK_WIDTH];
  end

  // Round-robin pick: first valid port after the last one granted, wrapping
  always_comb begin
    logic [SEL_WIDTH-1:0] w_cand;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 1; k <= PORTS; k++) begin
      w_cand = SEL_WIDTH'((int'(r_last_grant) + k) % PORTS);
      if (!w_grant_found && req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // A grant happens only from IDLE and only while the memory can take a command
  assign w_start = (r_state == S_IDLE) && mem_ready && w_grant_found;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: writes settle one cycle, reads wait for ready to return
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next_state = S_ISSUE;
      S_ISSUE:   w_next_state = r_write ? S_SETTLE : S_WAIT_RD;
      S_SETTLE:  w_next_state = S_IDLE;
      S_WAIT_RD: if (mem_ready) w_next_state = S_RETURN;
      S_RETURN:  w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Latch the winning request and capture read data when the memory delivers it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= '0;
      r_last_grant <= SEL_WIDTH'(PORTS - 1);
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_mask       <= '0;
      r_rd_data    <= '0;
    end else begin
      if (w_start) begin
        r_sel        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_write      <= req_write[w_grant_idx];
        r_addr       <= w_addr_arr[w_grant_idx];
        r_din        <= w_din_arr[w_grant_idx];
        r_mask       <= w_mask_arr[w_grant_idx];
      end
      if ((r_state == S_WAIT_RD) && mem_ready) begin
        r_rd_data <= mem_dout;
      end
    end
  end

  // Output decode: strobes and acks are pure functions of the current state
  always_comb begin
    req_ack  = '0;
    rd_valid = '0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_ISSUE: begin
        mem_we         = r_write;
        mem_re         = ~r_write;
        req_ack[r_sel] = 1'b1;
      end
      S_RETURN: begin
        rd_valid[r_sel] = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign mem_mask = r_mask;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_sp_dram_arbiter.sv
// Directed bench for sp_dram_arbiter with a small sp_dram behavioural model
// and a scoreboard of expected issues and read returns.
module tb_sp_dram_arbiter;

  localparam int P  = 4;
  localparam int SW = 2;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int MW = 16;

  logic              clk;
  logic              rst;
  logic [P-1:0]      req_valid;
  logic [P-1:0]      req_write;
  logic [P*AW-1:0]   req_addr;
  logic [P*DW-1:0]   req_din;
  logic [P*MW-1:0]   req_mask;
  logic [P-1:0]      req_ack;
  logic [P-1:0]      rd_valid;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [MW-1:0]     mem_mask;
  logic              mem_we;
  logic              mem_re;
  logic [DW-1:0]     mem_dout;
  logic              mem_ready;
  logic              busy;

  sp_dram_arbiter #(
    .PORTS(P), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_din(req_din), .req_mask(req_mask),
    .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- sp_dram model ----------------
  logic [DW-1:0] mem_arr [256];
  logic          m_ready;
  int            m_cnt;
  logic [7:0]    m_ra;
  logic [DW-1:0] m_dout;
  logic          hold_off;
  int            rd_lat;
  logic          pl_en;
  logic [7:0]    pl_addr;
  logic [DW-1:0] pl_data;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int j = 0; j < MW; j++) if (m[j]) r[8*j +: 8] = d[8*j +: 8];
    return r;
  endfunction

  assign mem_ready = m_ready & ~hold_off;
  assign mem_dout  = m_dout;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_ra    <= '0;
      m_dout  <= '0;
    end else begin
      if (pl_en) mem_arr[pl_addr] <= pl_data;
      if (mem_we) mem_arr[mem_addr[7:0]] <= merge(mem_arr[mem_addr[7:0]], mem_din, mem_mask);
      if (mem_re) begin
        m_ready <= 1'b0;
        m_cnt   <= rd_lat;
        m_ra    <= mem_addr[7:0];
      end else if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_dout  <= mem_arr[m_ra];
        m_cnt   <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            port;
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t rd_q[$];
  int   checks;
  int   errors;
  int   cyc;
  int   rise_cyc;
  logic prev_ready;
  int   rdv_cnt;
  int   rem [P];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int p, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    e.port = p; e.write = w; e.addr = a; e.data = d; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic post(input int p, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [MW-1:0] m, input int n);
    req_write[p]            = w;
    req_addr[p*AW +: AW]    = a;
    req_din[p*DW +: DW]     = d;
    req_mask[p*MW +: MW]    = m;
    rem[p]                  = rem[p] + n;
    req_valid[p]            = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    cyc++;
    if (rst) begin
      prev_ready = mem_ready;
      return;
    end
    chk("invariants", {127'd0, ($onehot0(req_ack) && $onehot0(rd_valid) && !(mem_we && mem_re)
        && ((req_ack != 0) == (mem_we || mem_re)))}, 128'd1);
    if (mem_we || mem_re) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {122'd0, mem_we, mem_re, req_ack}, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", req_ack, 128'(1) << e.port);
        chk("we_flag", mem_we, e.write);
        chk("mem_addr", mem_addr, e.addr);
        if (e.write) begin
          chk("mem_din", mem_din, e.data);
          chk("mem_mask", mem_mask, e.mask);
        end else begin
          rd_q.push_back(e);
        end
      end
    end
    for (int i = 0; i < P; i++) begin
      if (req_ack[i] && rem[i] > 0) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end
    end
    if (rd_valid != 0) begin
      rdv_cnt++;
      if (rd_q.size() == 0) begin
        chk("unexpected_rd_valid", rd_valid, 128'd0);
      end else begin
        e = rd_q.pop_front();
        chk("rd_port", rd_valid, 128'(1) << e.port);
        chk("rd_data", rd_data, e.data);
        chk("rd_latency", cyc, rise_cyc + 1);
      end
    end
    if (mem_ready && !prev_ready) rise_cyc = cyc;
    prev_ready = mem_ready;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rd_q.size() == 0 && !busy && req_valid == 0) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, {127'd0, (n < maxc)}, 128'd1);
  endtask

  initial begin
    int n;
    int rdv0;
    logic [DW-1:0] pv, dv, ev;
    checks = 0; errors = 0; cyc = 0; rise_cyc = -10; prev_ready = 1'b0; rdv_cnt = 0;
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_din = '0; req_mask = '0;
    hold_off = 1'b0; rd_lat = 5; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < P; i++) rem[i] = 0;

    // Reset state
    step(); step(); step();
    chk("rst_strobes", {119'd0, req_ack, rd_valid, mem_we, mem_re, busy}, 128'd0);
    chk("rst_rd_data", rd_data, 128'd0);
    chk("rst_mem_bus", {mem_addr, mem_mask}, 128'd0);
    chk("rst_mem_din", mem_din, 128'd0);
    rst = 1'b0;
    step();

    // 1: single write from port 2
    push_exp(2, 1'b1, 26'h10, {16{8'hA5}}, 16'hFFFF);
    post(2, 1'b1, 26'h10, {16{8'hA5}}, 16'hFFFF, 1);
    step();
    chk("t1_we_ack", {122'd0, mem_we, mem_re, req_ack}, {122'd0, 1'b1, 1'b0, 4'b0100});
    chk("t1_mem_addr", mem_addr, 128'h10);
    step();
    chk("t1_busy_settle", busy, 128'd1);
    step();
    chk("t1_busy_idle", busy, 128'd0);

    // 2: single read from port 1, memory returns after a delay
    preload(8'h20, 128'h1234);
    rd_lat = 5;
    rdv0 = rdv_cnt;
    push_exp(1, 1'b0, 26'h20, 128'h1234, 16'h0);
    post(1, 1'b0, 26'h20, '0, '0, 1);
    wait_done("t2_done", 60);
    chk("t2_rd_valid_count", rdv_cnt - rdv0, 128'd1);
    chk("t2_rd_data_held", rd_data, 128'h1234);

    // 6: masked write then readback of merged bytes
    pv = 128'h00112233445566778899AABBCCDDEEFF;
    dv = 128'hA0A1A2A3A4A5A6A7B0B1B2B3B4B5B6B7;
    ev = 128'h0011223344556677B0B1B2B3B4B5B6B7;
    preload(8'h50, pv);
    push_exp(0, 1'b1, 26'h50, dv, 16'h00FF);
    post(0, 1'b1, 26'h50, dv, 16'h00FF, 1);
    wait_done("t6_write_done", 30);
    push_exp(0, 1'b0, 26'h50, ev, 16'h0);
    post(0, 1'b0, 26'h50, '0, '0, 1);
    wait_done("t6_read_done", 60);
    chk("t6_merged_readback", rd_data, ev);

    // 3: all ports write continuously after reset -> strict rotation
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < P; p++)
        push_exp(p, 1'b1, 26'(26'h100 + p), 128'(p + 1), 16'hFFFF);
    for (int p = 0; p < P; p++) post(p, 1'b1, 26'(26'h100 + p), 128'(p + 1), 16'hFFFF, 2);
    wait_done("t3_done", 100);

    // 4: memory not ready holds off the grant
    hold_off = 1'b1;
    push_exp(3, 1'b1, 26'h30, 128'hBEEF, 16'hFFFF);
    post(3, 1'b1, 26'h30, 128'hBEEF, 16'hFFFF, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_no_issue", {121'd0, mem_we, mem_re, req_ack, busy}, 128'd0);
    end
    hold_off = 1'b0;
    step();
    chk("t4_p3_issue", {123'd0, mem_we, req_ack}, {123'd0, 1'b1, 4'b1000});
    wait_done("t4_done", 20);

    // 5: reset during WAIT_RD discards the read, priority back to port 0
    rd_lat = 12;
    rdv0 = rdv_cnt;
    push_exp(0, 1'b0, 26'h20, 128'h1234, 16'h0);
    post(0, 1'b0, 26'h20, '0, '0, 1);
    n = 0;
    while (req_ack[0] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("t5_ack_seen", req_ack[0], 128'd1);
    step(); step();
    chk("t5_busy_wait_rd", busy, 128'd1);
    rst = 1'b1;
    step();
    rd_q.delete();
    chk("t5_rst_strobes", {119'd0, req_ack, rd_valid, mem_we, mem_re, busy}, 128'd0);
    chk("t5_rst_rd_data", rd_data, 128'd0);
    chk("t5_rst_mem_bus", {mem_addr, mem_mask}, 128'd0);
    rst = 1'b0;
    rd_lat = 5;
    for (int i = 0; i < 16; i++) step();
    chk("t5_no_rd_valid", rdv_cnt - rdv0, 128'd0);
    push_exp(0, 1'b1, 26'h40, 128'hCAFE, 16'hFFFF);
    push_exp(1, 1'b0, 26'h20, 128'h1234, 16'h0);
    post(0, 1'b1, 26'h40, 128'hCAFE, 16'hFFFF, 1);
    post(1, 1'b0, 26'h20, '0, '0, 1);
    wait_done("t5_post_reset_done", 60);
    chk("t5_rd_data", rd_data, 128'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
